// File: rtl/pool2d_stream_if.sv
// Pixel/pool stream bundle for pool2d_stream. With POOL_ARGMAX_EN defined the
// bundle also carries the per-lane {row,col} argmax of each pooled pixel.
interface pool2d_stream_if #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 16
`ifdef POOL_ARGMAX_EN
  , parameter int AM_W   = 8
`endif
);
  logic                       start;
  logic                       mode;
  logic                       in_valid;
  logic                       in_ready;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [CHANNELS*DATA_W-1:0] out_data;
  logic                       out_last;
  logic                       busy;
  logic                       done;
`ifdef POOL_ARGMAX_EN
  logic [AM_W-1:0]            out_argmax;
`endif

  modport master (
    output start, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done
`ifdef POOL_ARGMAX_EN
    , input out_argmax
`endif
  );

  modport slave (
    input  start, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done
`ifdef POOL_ARGMAX_EN
    , output out_argmax
`endif
  );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming KERNELxKERNEL non-overlapping max/avg pooling over a raster pixel
// stream. Optional argmax export is enabled with `define POOL_ARGMAX_EN.

// Per-lane window accumulate: first pixel of a window overwrites, later pixels
// either win a strict signed compare (max) or are summed (avg).
module pool2d_lane #(
  parameter int DATA_W = 16,
  parameter int IW     = 2
) (
  input  logic                   mode_i,
  input  logic                   first_i,
  input  logic [DATA_W-1:0]      pix_i,
  input  logic [DATA_W+IW-1:0]   acc_i,
  output logic [DATA_W+IW-1:0]   acc_o,
  output logic [DATA_W-1:0]      res_o
`ifdef POOL_ARGMAX_EN
  , input  logic [IW-1:0]        idx_i
  , input  logic [IW-1:0]        pos_i
  , output logic [IW-1:0]        idx_o
  , output logic [IW-1:0]        res_idx_o
`endif
);
  localparam int ACC_W = DATA_W + IW;

  logic signed [ACC_W-1:0] pix_x, acc_s;
  logic                    take;

  assign pix_x = {{IW{pix_i[DATA_W-1]}}, pix_i};
  assign acc_s = acc_i;
  assign take  = first_i || (!mode_i && (pix_x > acc_s));

  always_comb begin
    acc_o = acc_i;
    if (take)        acc_o = pix_x;
    else if (mode_i) acc_o = acc_s + pix_x;
  end

  // Avg result is the arithmetic shift by log2(K*K), i.e. the top DATA_W bits.
  assign res_o = mode_i ? acc_o[ACC_W-1 -: DATA_W] : acc_o[DATA_W-1:0];

`ifdef POOL_ARGMAX_EN
  assign idx_o     = take ? pos_i : idx_i;
  assign res_idx_o = mode_i ? '0 : idx_o;
`endif
endmodule

module pool2d_stream #(
  parameter int FM_W     = 62,
  parameter int FM_H     = 62,
  parameter int KERNEL   = 2,
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  pool2d_stream_if.slave bus
);
  localparam int KB    = (KERNEL == 4) ? 2 : 1;
  localparam int IW    = 2 * KB;
  localparam int ACC_W = DATA_W + IW;
  localparam int OW    = FM_W / KERNEL;
  localparam int OH    = FM_H / KERNEL;
  localparam int XW    = $clog2(FM_W + 1);
  localparam int YW    = $clog2(FM_H + 1);
  localparam int OIW   = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(FM_W - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(FM_H - 1);
  localparam logic [XW-1:0]  X_GRID  = XW'(OW * KERNEL);
  localparam logic [YW-1:0]  Y_GRID  = YW'(OH * KERNEL);
  localparam logic [XW-1:0]  X_GLAST = XW'(OW * KERNEL - 1);
  localparam logic [YW-1:0]  Y_GLAST = YW'(OH * KERNEL - 1);
  localparam logic [OIW-1:0] OX_LAST = OIW'(OW - 1);
  localparam logic [KB-1:0]  K_LAST  = KB'(KERNEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                     state_q;
  logic                       mode_q, pix_en_q, pix_done_q, last_out_q;
  logic                       busy_q, done_q;
  logic [XW-1:0]              x_q;
  logic [YW-1:0]              y_q;
  logic [OIW-1:0]             ox_q;
  logic [KB-1:0]              i_q, j_q;
  logic                       out_valid_q, out_last_q;
  logic [CHANNELS*DATA_W-1:0] out_data_q;

  logic [CHANNELS-1:0][ACC_W-1:0] rb_q [OW];
  logic [CHANNELS-1:0][ACC_W-1:0] acc_nx;
  logic [CHANNELS-1:0][DATA_W-1:0] res;

`ifdef POOL_ARGMAX_EN
  logic [CHANNELS-1:0][IW-1:0] ib_q [OW];
  logic [CHANNELS-1:0][IW-1:0] idx_nx, res_idx;
  logic [CHANNELS*IW-1:0]      am_q;
`endif

  logic in_ready, px_acc, in_grid, first, win_end, grid_last, frame_last, out_hs;

  assign in_ready   = pix_en_q && (!out_valid_q || bus.out_ready);
  assign px_acc     = bus.in_valid && in_ready;
  assign in_grid    = (x_q < X_GRID) && (y_q < Y_GRID);
  assign first      = (i_q == '0) && (j_q == '0);
  assign win_end    = (i_q == K_LAST) && (j_q == K_LAST);
  assign grid_last  = (x_q == X_GLAST) && (y_q == Y_GLAST);
  assign frame_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign out_hs     = out_valid_q && bus.out_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool2d_lane #(.DATA_W(DATA_W), .IW(IW)) u_lane (
      .mode_i    (mode_q),
      .first_i   (first),
      .pix_i     (bus.in_data[c*DATA_W +: DATA_W]),
      .acc_i     (rb_q[ox_q][c]),
      .acc_o     (acc_nx[c]),
      .res_o     (res[c])
`ifdef POOL_ARGMAX_EN
      , .idx_i     (ib_q[ox_q][c])
      , .pos_i     ({i_q, j_q})
      , .idx_o     (idx_nx[c])
      , .res_idx_o (res_idx[c])
`endif
    );
  end

  // Row buffer carries no reset: the first pixel of every window overwrites it.
  always_ff @(posedge clk) begin
    if (px_acc && in_grid) begin
      rb_q[ox_q] <= acc_nx;
`ifdef POOL_ARGMAX_EN
      ib_q[ox_q] <= idx_nx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      pix_en_q    <= 1'b0;
      pix_done_q  <= 1'b0;
      last_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ox_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef POOL_ARGMAX_EN
      am_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;

      // KERNEL is a power of two, so i/j wrap naturally within KB bits.
      if (px_acc) begin
        if (x_q == X_LAST) begin
          x_q  <= '0;
          j_q  <= '0;
          ox_q <= '0;
          y_q  <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
          i_q  <= (y_q == Y_LAST) ? '0 : i_q + KB'(1);
        end else begin
          x_q <= x_q + XW'(1);
          j_q <= j_q + KB'(1);
          if (j_q == K_LAST && ox_q != OX_LAST) ox_q <= ox_q + OIW'(1);
        end
        if (frame_last) begin
          pix_en_q   <= 1'b0;
          pix_done_q <= 1'b1;
        end
      end

      if (px_acc && in_grid && win_end) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
        out_last_q  <= (ox_q == OX_LAST) && (y_q == Y_GLAST);
`ifdef POOL_ARGMAX_EN
        am_q        <= res_idx;
`endif
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end

      if (out_hs && out_last_q) last_out_q <= 1'b1;

      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q    <= S_RUN;
          mode_q     <= bus.mode;
          pix_en_q   <= 1'b1;
          pix_done_q <= 1'b0;
          last_out_q <= 1'b0;
          busy_q     <= 1'b1;
          x_q        <= '0;
          y_q        <= '0;
          ox_q       <= '0;
          i_q        <= '0;
          j_q        <= '0;
        end
        S_RUN: if (px_acc && grid_last) state_q <= S_FLUSH;
        // Wait for both the last beat handshake and the last frame pixel.
        S_FLUSH: if ((last_out_q || (out_hs && out_last_q)) &&
                     (pix_done_q || (px_acc && frame_last))) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef POOL_ARGMAX_EN
  assign bus.out_argmax = am_q;
`endif
endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboard bench for pool2d_stream on a 5x5 frame, K=2, 4 lanes: the model
// pools each frame from plain arithmetic; a monitor checks every output beat.
module tb_pool2d_stream;
  localparam int FW = 5, FH = 5, K = 2, C = 4, DW = 16;
  localparam int OWD = FW / K, OHD = FH / K, NPIX = FW * FH;

  typedef struct {
    logic [C*DW-1:0] data;
    logic            last;
    logic [2*C-1:0]  am;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0, errs = 0, cyc = 0;
  int   hs_cnt = 0, last_out_cyc = -1, last_px_cyc = -1;
  int   stall_gen = 0, stall_base = 0;
  bit   full_rate = 1'b1, cur_mode = 1'b0;
  exp_t sbq[$];
  int   fr [NPIX][C];

  pool2d_stream_if #(.CHANNELS(C), .DATA_W(DW)
`ifdef POOL_ARGMAX_EN
    , .AM_W(2*C)
`endif
  ) bus ();

  pool2d_stream #(.FM_W(FW), .FM_H(FH), .KERNEL(K), .CHANNELS(C), .DATA_W(DW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: random or full rate, with a 10-cycle stall on request.
  initial begin
    int last_gen = 0, stall_left = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_gen != last_gen && hs_cnt > stall_base) begin
        stall_left = 10;
        last_gen = stall_gen;
      end
      if (stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: every presented beat must equal the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid) begin
      nvec++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL unexpected_beat got=%h", bus.out_data);
      end else begin
        if (bus.out_data !== sbq[0].data || bus.out_last !== sbq[0].last) begin
          errs++;
          $display("FAIL beat got=%h last=%b want=%h last=%b",
                   bus.out_data, bus.out_last, sbq[0].data, sbq[0].last);
        end
`ifdef POOL_ARGMAX_EN
        if (bus.out_argmax !== sbq[0].am) begin
          errs++;
          $display("FAIL argmax got=%h want=%h", bus.out_argmax, sbq[0].am);
        end
`endif
        if (bus.out_ready) begin
          if (sbq[0].last) last_out_cyc = cyc;
          void'(sbq.pop_front());
          hs_cnt++;
        end else if (bus.in_ready) begin
          errs++;
          $display("FAIL in_ready_in_stall got=1 want=0");
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

  task automatic gen_frame(input int kind);
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < C; c++)
        fr[p][c] = (kind == 2) ? int'($urandom_range(0, 6)) - 3
                               : int'($urandom_range(0, 65535)) - 32768;
    if (kind == 1) begin
      fr[0][0] = -7; fr[1][0] = -3; fr[FW][0] = -9; fr[FW+1][0] = -5;
      fr[2][0] = 4;  fr[3][0] = 4;  fr[FW+2][0] = 4; fr[FW+3][0] = 4;
      for (int p = 0; p < NPIX; p++) fr[p][1] = p;
    end
  endtask

  task automatic push_expect(input bit md);
    exp_t e;
    int best, bi, sum, v, q;
    for (int oy = 0; oy < OHD; oy++)
      for (int ox = 0; ox < OWD; ox++) begin
        e.data = '0;
        e.am = '0;
        for (int c = 0; c < C; c++) begin
          best = 0; bi = 0; sum = 0;
          for (int dy = 0; dy < K; dy++)
            for (int dx = 0; dx < K; dx++) begin
              v = fr[(oy*K+dy)*FW + ox*K + dx][c];
              if ((dy == 0 && dx == 0) || v > best) begin
                best = v;
                bi = dy * 2 + dx;
              end
              sum += v;
            end
          q = sum / (K*K);
          if ((sum % (K*K)) != 0 && sum < 0) q = q - 1;
          e.data[c*DW +: DW] = md ? q[DW-1:0] : best[DW-1:0];
          e.am[c*2 +: 2] = md ? 2'b00 : bi[1:0];
        end
        e.last = (oy == OHD-1) && (ox == OWD-1);
        sbq.push_back(e);
      end
  endtask

  task automatic pulse_start(input bit md);
    bus.start = 1'b1;
    bus.mode = md;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input bit gaps, input int start_at);
    int to;
    for (int p = 0; p < n; p++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      for (int c = 0; c < C; c++) bus.in_data[c*DW +: DW] = fr[p][c][DW-1:0];
      if (p == start_at) begin
        bus.start = 1'b1;
        bus.mode = ~cur_mode;
      end
      to = 0;
      @(negedge clk);
      while (!bus.in_ready && to < 200) begin
        @(negedge clk);
        to++;
      end
      if (to >= 200) begin
        nvec++; errs++;
        $display("FAIL in_ready_timeout got=0 want=1 pixel=%0d", p);
      end
      last_px_cyc = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit md, input int kind, input bit gaps,
                           input bit stall, input int start_at);
    int to, want;
    gen_frame(kind);
    push_expect(md);
    cur_mode = md;
    full_rate = !gaps && !stall;
    last_out_cyc = -1;
    if (stall) begin
      stall_base = hs_cnt;
      stall_gen++;
    end
    pulse_start(md);
    @(negedge clk);
    nvec++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL after_start got=rdy%b busy%b want=rdy1 busy1", bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
    send_pixels(NPIX, gaps, start_at);
    to = 0;
    @(negedge clk);
    while (!bus.done && to < 100) begin
      @(negedge clk);
      to++;
    end
    want = ((last_px_cyc > last_out_cyc) ? last_px_cyc : last_out_cyc) + 1;
    nvec++;
    if (to >= 100 || cyc != want) begin
      errs++;
      $display("FAIL done_cycle got=%0d want=%0d", (to >= 100) ? -1 : cyc, want);
    end
    @(negedge clk);
    nvec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || sbq.size() != 0) begin
      errs++;
      $display("FAIL post_done got=done%b busy%b rdy%b left%0d want=0000",
               bus.done, bus.busy, bus.in_ready, sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    nvec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL %s got=rdy%b v%b d%h l%b b%b dn%b want=all zero", tag, bus.in_ready,
               bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done);
    end
`ifdef POOL_ARGMAX_EN
    nvec++;
    if (bus.out_argmax !== '0) begin
      errs++;
      $display("FAIL %s_argmax got=%h want=0", tag, bus.out_argmax);
    end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(1'b0, 1, 1'b0, 1'b1, -1);   // directed max, downstream stall
    run_frame(1'b1, 1, 1'b0, 1'b0, -1);   // same windows, avg, full rate
    run_frame(1'b0, 2, 1'b1, 1'b0, -1);   // small values: many ties

    // Abort mid-frame after 6 pixels.
    gen_frame(0);
    cur_mode = 1'b0;
    pulse_start(1'b0);
    send_pixels(6, 1'b0, -1);
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(1'b1, 0, 1'b1, 1'b0, 8);    // start pulsed during RUN is ignored
    for (int f = 0; f < 6; f++)
      run_frame(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
